mem_stage_data_memory: RTL and testbench

MEM-stage data memory for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and MEM_WB_Pipeline_Module, and its read data drives Data_Memory_Output_IN of that register. It supports byte, halfword and word loads and stores, big-endian, with sign or zero extension on loads. A wait-state FSM stalls the pipeline for a configurable access latency, and misaligned accesses are flagged.

---
 rtl/mem_stage_data_memory.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_data_memory.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_data_memory.sv
// rtl/mem_stage_data_memory.sv - MEM-stage big-endian data memory with wait-state stall FSM
// Optional DMEM_ACCESS_COUNT_EN adds Access_Count_Output, a count of completed legal accesses.
module mem_stage_data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_Input,
    input  logic        MemWrite_Input,
    input  logic [1:0]  Mem_Size_Input,
    input  logic        Mem_Unsigned_Input,
    input  logic [31:0] ALU_Result_Input,
    input  logic [31:0] Write_Data_Input,
    output logic [31:0] Data_Memory_Output,
    output logic        Mem_Stall_Output,
    output logic        Misaligned_Exception_Output
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] Access_Count_Output
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          illegal;
    logic          legal;
    logic          completing;
    logic          stalling;
    logic          wr_en;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   load_val;
    logic          unused_addr_bits;

    assign widx = ALU_Result_Input[AW+1:2];
    assign lane = ALU_Result_Input[1:0];
    assign unused_addr_bits = ^ALU_Result_Input[31:AW+2];

    always_comb begin
        req     = MemRead_Input | MemWrite_Input;
        illegal = req & ((Mem_Size_Input == 2'b11)
                       | ((Mem_Size_Input == SZ_HALF) & lane[0])
                       | ((Mem_Size_Input == SZ_WORD) & (lane != 2'b00))
                       | (MemRead_Input & MemWrite_Input));
        legal   = req & ~illegal;
    end

    // Stall and completion decode; everything is masked while reset is held.
    always_comb begin
        completing = 1'b0;
        stalling   = 1'b0;
        if (legal && !rst) begin
            if (state == IDLE) begin
                if (HAS_WAIT) stalling = 1'b1;
                else          completing = 1'b1;
            end else begin
                if (cnt != 4'd0) stalling = 1'b1;
                else             completing = 1'b1;
            end
        end
    end

    assign Mem_Stall_Output            = stalling;
    assign Misaligned_Exception_Output = illegal & ~rst;
    assign wr_en                       = completing & MemWrite_Input;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (legal && HAS_WAIT) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (!legal) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // be[3] is the most significant byte, i.e. big-endian byte address 0.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'd0;
        case (Mem_Size_Input)
            SZ_BYTE: begin
                be    = 4'b1000 >> lane;
                wdata = {4{Write_Data_Input[7:0]}};
            end
            SZ_HALF: begin
                be    = lane[1] ? 4'b0011 : 4'b1100;
                wdata = {2{Write_Data_Input[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = Write_Data_Input;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rword    = mem[widx];
        load_val = 32'd0;
        case (Mem_Size_Input)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    load_val[7:0] = rword[31:24];
                    2'd1:    load_val[7:0] = rword[23:16];
                    2'd2:    load_val[7:0] = rword[15:8];
                    default: load_val[7:0] = rword[7:0];
                endcase
                load_val[31:8] = {24{~Mem_Unsigned_Input & load_val[7]}};
            end
            SZ_HALF: begin
                load_val[15:0]  = lane[1] ? rword[15:0] : rword[31:16];
                load_val[31:16] = {16{~Mem_Unsigned_Input & load_val[15]}};
            end
            SZ_WORD: load_val = rword;
            default: load_val = 32'd0;
        endcase
    end

    assign Data_Memory_Output = (completing & MemRead_Input) ? load_val : 32'd0;

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Access_Count_Output <= 32'd0;
        end else if (completing) begin
            Access_Count_Output <= Access_Count_Output + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_data_memory.sv
// tb/tb_mem_stage_data_memory.sv - directed bench for mem_stage_data_memory (WAIT_CYCLES 1 and 3)
module tb_mem_stage_data_memory;

    logic        clk;
    logic        rst  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [1:0]  sz   [2];
    logic        uns  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] dout [2];
    logic        stall[2];
    logic        exc  [2];
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] acnt [2];
`endif

    int vectors = 0;
    int errors  = 0;
    int ndone [2];

    mem_stage_data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst[0]), .MemRead_Input(rd[0]), .MemWrite_Input(wr[0]),
        .Mem_Size_Input(sz[0]), .Mem_Unsigned_Input(uns[0]), .ALU_Result_Input(addr[0]),
        .Write_Data_Input(wd[0]), .Data_Memory_Output(dout[0]), .Mem_Stall_Output(stall[0]),
        .Misaligned_Exception_Output(exc[0])
`ifdef DMEM_ACCESS_COUNT_EN
        , .Access_Count_Output(acnt[0])
`endif
    );

    mem_stage_data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst[1]), .MemRead_Input(rd[1]), .MemWrite_Input(wr[1]),
        .Mem_Size_Input(sz[1]), .Mem_Unsigned_Input(uns[1]), .ALU_Result_Input(addr[1]),
        .Write_Data_Input(wd[1]), .Data_Memory_Output(dout[1]), .Mem_Stall_Output(stall[1]),
        .Misaligned_Exception_Output(exc[1])
`ifdef DMEM_ACCESS_COUNT_EN
        , .Access_Count_Output(acnt[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a, input logic [31:0] data);
        rd[d] = r; wr[d] = w; sz[d] = s; uns[d] = u; addr[d] = a; wd[d] = data;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    // Holds a legal request until it completes, checking stall length and load data.
    task automatic access(input int d, input logic r, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] a, input logic [31:0] data,
                          input int exp_stalls, input logic [31:0] exp_data, input string tag);
        int          stalls;
        logic        done;
        logic [31:0] got;
        stalls = 0;
        done   = 1'b0;
        got    = 32'd0;
        drive(d, r, w, s, u, a, data);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall[d]) begin
                stalls++;
                chk({tag, "_dout_in_stall"}, dout[d], 32'd0);
            end else begin
                done = 1'b1;
                got  = dout[d];
            end
        end
        chk({tag, "_completed"}, {31'd0, done}, 32'd1);
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_data"}, got, r ? exp_data : 32'd0);
        if (done) ndone[d]++;
        @(posedge clk);
        #1;
        idle(d);
    endtask

    task automatic illegal_access(input int d, input logic r, input logic w, input logic [1:0] s,
                                  input logic [31:0] a, input logic [31:0] data, input string tag);
        drive(d, r, w, s, 1'b0, a, data);
        @(negedge clk);
        chk({tag, "_exc"}, {31'd0, exc[d]}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stall[d]}, 32'd0);
        chk({tag, "_dout"}, dout[d], 32'd0);
        @(posedge clk);
        #1;
        idle(d);
    endtask

    task automatic chk_count(input int d, input string tag);
`ifdef DMEM_ACCESS_COUNT_EN
        chk(tag, acnt[d], ndone[d]);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        ndone[0] = 0;
        ndone[1] = 0;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        idle(0);
        idle(1);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall[0]}, 32'd0);
        chk("rst_exc", {31'd0, exc[0]}, 32'd0);
        chk("rst_dout", dout[0], 32'd0);
        chk_count(0, "rst_count");
        @(posedge clk);
        #1;
        idle(0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // WAIT_CYCLES = 1
        access(0, 0, 1, 2'b10, 0, 32'h10, 32'h12345678, 1, 32'd0,         "sw10");
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'd0,        1, 32'h12345678,  "lw10_a");
        access(0, 0, 1, 2'b00, 0, 32'h13, 32'h555555AB, 1, 32'd0,         "sb13");
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'd0,        1, 32'h123456AB,  "lw10_b");
        access(0, 1, 0, 2'b00, 0, 32'h13, 32'd0,        1, 32'hFFFFFFAB,  "lb13");
        access(0, 1, 0, 2'b00, 1, 32'h13, 32'd0,        1, 32'h000000AB,  "lbu13");
        access(0, 1, 0, 2'b00, 0, 32'h10, 32'd0,        1, 32'h00000012,  "lb10");
        access(0, 0, 1, 2'b01, 0, 32'h12, 32'hCAFE8001, 1, 32'd0,         "sh12");
        access(0, 1, 0, 2'b01, 0, 32'h12, 32'd0,        1, 32'hFFFF8001,  "lh12");
        access(0, 1, 0, 2'b01, 1, 32'h12, 32'd0,        1, 32'h00008001,  "lhu12");
        access(0, 1, 0, 2'b01, 0, 32'h10, 32'd0,        1, 32'h00001234,  "lh10");
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'd0,        1, 32'h12348001,  "lw10_c");
        access(0, 0, 1, 2'b10, 0, 32'h04, 32'hDEADBEEF, 1, 32'd0,         "sw04");

        illegal_access(0, 1, 0, 2'b10, 32'h02, 32'd0,        "lw02");
        illegal_access(0, 0, 1, 2'b01, 32'h05, 32'h00001111, "sh05");
        illegal_access(0, 0, 1, 2'b10, 32'h06, 32'h00000000, "sw06");
        illegal_access(0, 1, 0, 2'b11, 32'h10, 32'd0,        "size11");
        illegal_access(0, 1, 1, 2'b10, 32'h10, 32'h00000000, "rdwr");
        access(0, 1, 0, 2'b10, 0, 32'h04, 32'd0, 1, 32'hDEADBEEF, "lw04_after_illegal");
        access(0, 1, 0, 2'b10, 0, 32'h10, 32'd0, 1, 32'h12348001, "lw10_after_illegal");

        access(0, 1, 0, 2'b10, 0, 32'h410, 32'd0,        1, 32'h12348001, "lw410_alias");
        access(0, 0, 1, 2'b10, 0, 32'h414, 32'h0BADF00D, 1, 32'd0,        "sw414_alias");
        access(0, 1, 0, 2'b10, 0, 32'h14,  32'd0,        1, 32'h0BADF00D, "lw14_alias");
        chk_count(0, "count_w1");

        // WAIT_CYCLES = 3: flush after two stall cycles leaves memory untouched
        access(1, 0, 1, 2'b10, 0, 32'h00, 32'hA5A5A5A5, 3, 32'd0, "w3_sw00");
        drive(1, 0, 1, 2'b10, 0, 32'h00, 32'hFFFFFFFF);
        @(negedge clk);
        chk("flush_stall0", {31'd0, stall[1]}, 32'd1);
        @(negedge clk);
        chk("flush_stall1", {31'd0, stall[1]}, 32'd1);
        @(posedge clk);
        #1;
        idle(1);
        @(negedge clk);
        chk("flush_stall_drop", {31'd0, stall[1]}, 32'd0);
        @(posedge clk);
        #1;
        access(1, 1, 0, 2'b10, 0, 32'h00, 32'd0, 3, 32'hA5A5A5A5, "w3_lw_after_flush");

        // Reset mid-BUSY drops the stall at once and suppresses the write
        drive(1, 0, 1, 2'b10, 0, 32'h00, 32'h5A5A5A5A);
        @(negedge clk);
        chk("rstmid_stall0", {31'd0, stall[1]}, 32'd1);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        chk("rstmid_stall_drop", {31'd0, stall[1]}, 32'd0);
        @(posedge clk);
        #1;
        idle(1);
        rst[1] = 1'b0;
        ndone[1] = 0;
        access(1, 1, 0, 2'b10, 0, 32'h00, 32'd0, 3, 32'hA5A5A5A5, "w3_lw_after_rst");
        chk_count(1, "count_w3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
